// File: rtl/ps2_key_tracker.sv
// PS/2 receiver with glitch filter, frame checker and make/break decoder
// that tracks up to two simultaneously held keys.
module ps2_key_tracker #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] key1_code,
  output logic       key1_ext,
  output logic       key1_on,
  output logic [7:0] key2_code,
  output logic       key2_ext,
  output logic       key2_on,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam logic [7:0]  FLT_MAX = 8'(FILTER_LEN - 1);
  localparam logic [15:0] TO_MAX  = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]  clk_sync, dat_sync;
  logic        clk_s, dat_s;
  logic [7:0]  flt_cnt;
  logic        flt_clk, flt_clk_d, fall;
  state_t      state, state_nxt;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic        par_bit;
  logic [15:0] to_cnt;
  logic        timeout, frame_ok, frame_bad;
  logic        ext_pend, brk_pend;
  logic [2:0]  skip_cnt;
  logic        match1, match2;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  // Filtered clock only moves after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      flt_cnt   <= '0;
      flt_clk   <= 1'b1;
      flt_clk_d <= 1'b1;
    end else begin
      flt_clk_d <= flt_clk;
      if (clk_s == flt_clk) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_MAX) begin
        flt_clk <= clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 8'd1;
      end
    end
  end

  assign fall    = flt_clk_d & ~flt_clk;
  assign timeout = (state != S_IDLE) && (to_cnt == TO_MAX) && !fall;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = S_IDLE;
    end else if (fall) begin
      case (state)
        S_IDLE:   if (!dat_s) state_nxt = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_nxt = S_PARITY;
        S_PARITY: state_nxt = S_STOP;
        S_STOP:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    frame_ok  = 1'b0;
    frame_bad = timeout;
    if (fall && state == S_STOP) begin
      if (dat_s && (^{shift, par_bit})) frame_ok  = 1'b1;
      else                              frame_bad = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      shift      <= '0;
      bit_cnt    <= '0;
      par_bit    <= 1'b0;
      to_cnt     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_byte    <= '0;
    end else begin
      byte_valid <= frame_ok;
      frame_err  <= frame_bad;
      if (frame_ok) rx_byte <= shift;
      if (state == S_IDLE || fall) to_cnt <= '0;
      else if (to_cnt != TO_MAX)   to_cnt <= to_cnt + 16'd1;
      if (fall) begin
        case (state)
          S_IDLE:   bit_cnt <= '0;
          S_DATA: begin
            shift   <= {dat_s, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_PARITY: par_bit <= dat_s;
          default:  ;
        endcase
      end
    end
  end

  assign match1 = key1_on && key1_code == rx_byte && key1_ext == ext_pend;
  assign match2 = key2_on && key2_code == rx_byte && key2_ext == ext_pend;

  // Slot 2 is never promoted; a freed slot 1 simply takes the next new make.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      ext_pend  <= 1'b0;
      brk_pend  <= 1'b0;
      skip_cnt  <= '0;
      key1_code <= '0;
      key1_ext  <= 1'b0;
      key1_on   <= 1'b0;
      key2_code <= '0;
      key2_ext  <= 1'b0;
      key2_on   <= 1'b0;
    end else if (frame_err) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_valid) begin
      if (skip_cnt != 3'd0) begin
        skip_cnt <= skip_cnt - 3'd1;
      end else begin
        case (rx_byte)
          8'hE1: begin
            skip_cnt <= 3'd7;
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
          8'hE0: ext_pend <= 1'b1;
          8'hF0: brk_pend <= 1'b1;
          8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF: begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
          default: begin
            if (brk_pend) begin
              if (match1) key1_on <= 1'b0;
              if (match2) key2_on <= 1'b0;
            end else if (!(match1 || match2)) begin
              if (!key1_on) begin
                key1_on   <= 1'b1;
                key1_code <= rx_byte;
                key1_ext  <= ext_pend;
              end else if (!key2_on) begin
                key2_on   <= 1'b1;
                key2_code <= rx_byte;
                key2_ext  <= ext_pend;
              end
            end
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
